// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - multi-lane in-order writeback queue with retire ports and pending-write scoreboard
// Accepts up to LANES results per cycle, retires up to PORTS per cycle in accept order.
module wb_retire_queue #(
  parameter int LANES = 2,
  parameter int PORTS = 1,
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [LANES-1:0]             in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANES*DW-1:0]          in_wdata_i,
  input  logic [LANES*5-1:0]           in_waddr_i,
  input  logic [LANES-1:0]             in_we_i,
  input  logic [LANES*32-1:0]          in_pc_i,
  input  logic [LANES*32-1:0]          in_inst_i,
  output logic [PORTS-1:0]             rf_we_o,
  output logic [PORTS*5-1:0]           rf_waddr_o,
  output logic [PORTS*DW-1:0]          rf_wdata_o,
  output logic [PORTS-1:0]             rt_valid_o,
  output logic [PORTS*32-1:0]          rt_pc_o,
  output logic [PORTS*32-1:0]          rt_inst_o,
  output logic                         wb_active_o,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count_o,
  output logic [31:0]                  wb_busy_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0]    data_q [DEPTH];
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] we_q;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, n_in, n_out;
  logic          accept;

  logic [PW-1:0]    ridx  [PORTS];
  logic [PORTS-1:0] rvld, ren, kill;
  logic [PW-1:0]    off   [DEPTH];
  logic [DEPTH-1:0] occ;

  // Readiness looks only at registered occupancy so MEM never sees a retire-dependent path.
  assign in_ready_o = (count_q <= CW'(DEPTH - LANES));
  assign accept     = in_ready_o && (|in_valid_i);

  always_comb begin
    n_in = '0;
    for (int l = 0; l < LANES; l++) begin
      if (accept && in_valid_i[l]) n_in = n_in + CW'(1);
    end
    n_out   = (count_q > CW'(PORTS)) ? CW'(PORTS) : count_q;
    count_d = count_q + n_in - n_out;
    head_d  = head_q + PW'(n_out);
    tail_d  = tail_q + PW'(n_in);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        data_q[e] <= '0;
        addr_q[e] <= '0;
        pc_q[e]   <= '0;
        inst_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int l = 0; l < LANES; l++) begin
        if (accept && in_valid_i[l]) begin
          data_q[tail_q + PW'(l)] <= in_wdata_i[l*DW +: DW];
          addr_q[tail_q + PW'(l)] <= in_waddr_i[l*5 +: 5];
          pc_q[tail_q + PW'(l)]   <= in_pc_i[l*32 +: 32];
          inst_q[tail_q + PW'(l)] <= in_inst_i[l*32 +: 32];
          we_q[tail_q + PW'(l)]   <= in_we_i[l];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      ridx[p] = head_q + PW'(p);
      rvld[p] = (CW'(p) < n_out);
      ren[p]  = rvld[p] && we_q[ridx[p]] && (addr_q[ridx[p]] != 5'd0);
    end
  end

  // When two retiring entries target the same register, only the youngest writes.
  always_comb begin
    kill = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = p + 1; q < PORTS; q++) begin
        if (ren[q] && (addr_q[ridx[q]] == addr_q[ridx[p]])) kill[p] = 1'b1;
      end
    end
  end

  always_comb begin
    rf_we_o    = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rt_valid_o = '0;
    rt_pc_o    = '0;
    rt_inst_o  = '0;
    for (int p = 0; p < PORTS; p++) begin
      rt_valid_o[p] = rvld[p];
      if (rvld[p]) begin
        rt_pc_o[p*32 +: 32]   = pc_q[ridx[p]];
        rt_inst_o[p*32 +: 32] = inst_q[ridx[p]];
      end
      if (ren[p] && !kill[p]) begin
        rf_we_o[p]             = 1'b1;
        rf_waddr_o[p*5 +: 5]   = addr_q[ridx[p]];
        rf_wdata_o[p*DW +: DW] = data_q[ridx[p]];
      end
    end
  end

  always_comb begin
    wb_busy_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      off[e] = PW'(e) - head_q;
      occ[e] = (CW'(off[e]) < count_q);
      if (occ[e] && we_q[e] && (addr_q[e] != 5'd0)) wb_busy_o[addr_q[e]] = 1'b1;
    end
  end

  assign wb_active_o = |rt_valid_o;
  assign wb_count_o  = count_q;

endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - scoreboard bench for wb_retire_queue with PORTS=1 and PORTS=2 instances
// A per-instance queue model predicts every output each cycle; directed checks cover the named scenarios.
module tb_wb_retire_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  iv  [2];
  logic [4:0]  ia  [2][2];
  logic        iw  [2][2];
  logic [31:0] id  [2][2];
  logic [31:0] ipc [2][2];
  logic [31:0] iin [2][2];

  logic [63:0] bd [2];
  logic [63:0] bpc[2];
  logic [63:0] bin[2];
  logic [9:0]  ba [2];
  logic [1:0]  bw [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bd[i]  = {id[i][1], id[i][0]};
      bpc[i] = {ipc[i][1], ipc[i][0]};
      bin[i] = {iin[i][1], iin[i][0]};
      ba[i]  = {ia[i][1], ia[i][0]};
      bw[i]  = {iw[i][1], iw[i][0]};
    end
  end

  logic        rdy0, act0, rdy1, act1;
  logic [0:0]  rfwe0, rtv0;
  logic [4:0]  rfa0;
  logic [31:0] rfd0, rpc0, rin0, busy0, busy1;
  logic [1:0]  rfwe1, rtv1;
  logic [9:0]  rfa1;
  logic [63:0] rfd1, rpc1, rin1;
  logic [2:0]  cnt0, cnt1;

  wb_retire_queue #(.LANES(2), .PORTS(1), .DEPTH(4), .DW(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[0]), .in_ready_o(rdy0),
    .in_wdata_i(bd[0]), .in_waddr_i(ba[0]), .in_we_i(bw[0]), .in_pc_i(bpc[0]), .in_inst_i(bin[0]),
    .rf_we_o(rfwe0), .rf_waddr_o(rfa0), .rf_wdata_o(rfd0), .rt_valid_o(rtv0),
    .rt_pc_o(rpc0), .rt_inst_o(rin0), .wb_active_o(act0), .wb_count_o(cnt0), .wb_busy_o(busy0));

  wb_retire_queue #(.LANES(2), .PORTS(2), .DEPTH(4), .DW(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv[1]), .in_ready_o(rdy1),
    .in_wdata_i(bd[1]), .in_waddr_i(ba[1]), .in_we_i(bw[1]), .in_pc_i(bpc[1]), .in_inst_i(bin[1]),
    .rf_we_o(rfwe1), .rf_waddr_o(rfa1), .rf_wdata_o(rfd1), .rt_valid_o(rtv1),
    .rt_pc_o(rpc1), .rt_inst_o(rin1), .wb_active_o(act1), .wb_count_o(cnt1), .wb_busy_o(busy1));

  logic        o_rtv [2][2];
  logic        o_we  [2][2];
  logic [4:0]  o_a   [2][2];
  logic [31:0] o_d   [2][2];
  logic [31:0] o_pc  [2][2];
  logic [31:0] o_in  [2][2];
  logic [2:0]  o_cnt [2];
  logic [31:0] o_busy[2];
  logic        o_rdy [2];
  logic        o_act [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      o_rtv[0][p] = 1'b0; o_we[0][p] = 1'b0; o_a[0][p] = '0;
      o_d[0][p] = '0; o_pc[0][p] = '0; o_in[0][p] = '0;
      o_rtv[1][p] = rtv1[p]; o_we[1][p] = rfwe1[p]; o_a[1][p] = rfa1[p*5 +: 5];
      o_d[1][p] = rfd1[p*32 +: 32]; o_pc[1][p] = rpc1[p*32 +: 32]; o_in[1][p] = rin1[p*32 +: 32];
    end
    o_rtv[0][0] = rtv0[0]; o_we[0][0] = rfwe0[0]; o_a[0][0] = rfa0;
    o_d[0][0] = rfd0; o_pc[0][0] = rpc0; o_in[0][0] = rin0;
    o_cnt[0] = cnt0; o_cnt[1] = cnt1;
    o_busy[0] = busy0; o_busy[1] = busy1;
    o_rdy[0] = rdy0; o_rdy[1] = rdy1;
    o_act[0] = act0; o_act[1] = act1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] dat;
    logic [4:0]  a;
    logic        we;
  } ent_t;

  ent_t mq [2][$];

  // Reference model: an in-order list per instance; the oldest min(size, PORTS) entries retire each cycle.
  always @(negedge clk) begin : monitor
    int P, sz, nout;
    logic [31:0] eb, ed;
    logic [4:0]  ea;
    logic        ew, erdy;
    ent_t e, ne;
    if (!rst_n) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        P    = i + 1;
        sz   = mq[i].size();
        nout = (sz < P) ? sz : P;
        erdy = ((DEPTH - sz) >= LANES);
        assert ((iv[i] & (iv[i] + 2'd1)) == 2'b00) else $error("non-contiguous in_valid");
        eb = '0;
        foreach (mq[i][k]) if (mq[i][k].we && mq[i][k].a != 5'd0) eb[mq[i][k].a] = 1'b1;
        chk($sformatf("count%0d", i), o_cnt[i], sz);
        chk($sformatf("count_bound%0d", i), (o_cnt[i] <= DEPTH), 1);
        chk($sformatf("ready%0d", i), o_rdy[i], erdy);
        chk($sformatf("active%0d", i), o_act[i], (nout > 0));
        chk($sformatf("busy%0d", i), o_busy[i], eb);
        for (int p = 0; p < P; p++) begin
          chk($sformatf("rt_valid%0d[%0d]", i, p), o_rtv[i][p], (p < nout));
          ew = 1'b0; ea = '0; ed = '0;
          if (p < nout) begin
            e = mq[i][p];
            chk($sformatf("rt_pc%0d[%0d]", i, p), o_pc[i][p], e.pc);
            chk($sformatf("rt_inst%0d[%0d]", i, p), o_in[i][p], e.ins);
            ew = e.we && (e.a != 5'd0);
            for (int q = p + 1; q < nout; q++)
              if (mq[i][q].we && mq[i][q].a == e.a) ew = 1'b0;
            if (ew) begin ea = e.a; ed = e.dat; end
          end
          chk($sformatf("rf_we%0d[%0d]", i, p), o_we[i][p], ew);
          chk($sformatf("rf_waddr%0d[%0d]", i, p), o_a[i][p], ea);
          chk($sformatf("rf_wdata%0d[%0d]", i, p), o_d[i][p], ed);
        end
        repeat (nout) void'(mq[i].pop_front());
        if (erdy && iv[i] != 2'b00) begin
          for (int l = 0; l < LANES; l++) begin
            if (iv[i][l]) begin
              ne.pc = ipc[i][l]; ne.ins = iin[i][l]; ne.dat = id[i][l];
              ne.a = ia[i][l]; ne.we = iw[i][l];
              mq[i].push_back(ne);
            end
          end
        end
      end
    end
  end

  logic [31:0] pc_ctr;

  task automatic set_lane(input int i, input int l, input logic [4:0] a, input logic we, input logic [31:0] d);
    ia[i][l] = a; iw[i][l] = we; id[i][l] = d;
    ipc[i][l] = pc_ctr; iin[i][l] = $urandom;
    pc_ctr = pc_ctr + 32'd4;
    iv[i][l] = 1'b1;
  endtask

  task automatic rand_group(input int i, input int n);
    iv[i] = 2'b00;
    for (int l = 0; l < n; l++)
      set_lane(i, l, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds the presented group until the instance takes it, then withdraws it.
  task automatic send(input int i);
    int k;
    logic r;
    k = 0;
    do begin
      @(negedge clk);
      r = o_rdy[i];
      @(posedge clk); #1;
      k++;
    end while (!r && k < 50);
    if (!r) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout%0d: got no accept expected accept within 50 cycles", i);
    end
    iv[i] = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_ctr = 32'h1c000000;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 2'b00;
      for (int l = 0; l < 2; l++) begin
        ia[i][l] = '0; iw[i][l] = 1'b0; id[i][l] = '0; ipc[i][l] = '0; iin[i][l] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(1);

    // Asynchronous reset with three entries queued
    rand_group(0, 2); send(0);
    rand_group(0, 2); send(0);
    chk("pre_reset_count", cnt0, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we", {rfwe0, rfwe1}, 0);
    chk("rst_rt_valid", {rtv0, rtv1}, 0);
    chk("rst_waddr", {rfa0, rfa1}, 0);
    chk("rst_wdata0", rfd0, 0);
    chk("rst_wdata1", rfd1, 0);
    chk("rst_pc", {rpc0, rpc1[31:0]}, 0);
    chk("rst_inst", {rin0, rin1[31:0]}, 0);
    chk("rst_active", {act0, act1}, 0);
    chk("rst_count", {cnt0, cnt1}, 0);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_ready", {rdy0, rdy1}, 2'b11);
    @(negedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Random traffic on both instances
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 60; k++) begin
        int n;
        n = $urandom_range(0, 2);
        if (n == 0) idle(1);
        else begin rand_group(i, n); send(i); end
      end
      idle(6);
    end

    // Continuous two-per-cycle offer: queue fills and back-pressures
    for (int k = 0; k < 10; k++) begin rand_group(0, 2); send(0); end
    idle(8);

    // Ten single-lane pushes walk the pointers around twice
    pc_ctr = 32'h1c000000;
    for (int k = 0; k < 10; k++) begin rand_group(0, 1); send(0); end
    idle(6);

    // r5 then r6 in one group
    iv[0] = 2'b00;
    set_lane(0, 0, 5'd5, 1'b1, 32'h11);
    set_lane(0, 1, 5'd6, 1'b1, 32'h22);
    send(0);
    chk("t2_we_a", rfwe0, 1);
    chk("t2_addr_a", rfa0, 5);
    chk("t2_data_a", rfd0, 32'h11);
    chk("t2_busy_a", busy0[6:5], 2'b11);
    idle(1);
    chk("t2_addr_b", rfa0, 6);
    chk("t2_data_b", rfd0, 32'h22);
    chk("t2_busy_b", busy0[6:5], 2'b10);
    idle(1);
    chk("t2_we_c", rfwe0, 0);
    chk("t2_busy_c", busy0[6:5], 2'b00);
    idle(2);

    // r0 write: traced but never written, never busy
    pc_ctr = 32'h1c000000;
    iv[0] = 2'b00;
    set_lane(0, 0, 5'd0, 1'b1, 32'hdead);
    send(0);
    chk("t3_rt_valid", rtv0, 1);
    chk("t3_rt_pc", rpc0, 32'h1c000000);
    chk("t3_rf_we", rfwe0, 0);
    chk("t3_busy0", busy0[0], 0);
    idle(3);

    // Two ports retiring the same register: youngest wins
    iv[1] = 2'b00;
    set_lane(1, 0, 5'd7, 1'b1, 32'hA);
    set_lane(1, 1, 5'd7, 1'b1, 32'hB);
    send(1);
    chk("t5_rt_valid", rtv1, 2'b11);
    chk("t5_rf_we", rfwe1, 2'b10);
    chk("t5_waddr1", rfa1[9:5], 7);
    chk("t5_wdata1", rfd1[63:32], 32'hB);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
